// File: rtl/m_tx_frame_arb_if.sv
// Request/transmit bundle between the frame requesters, the byte transmitter
// and the response-path arbiter.
interface m_tx_frame_arb_if;
    logic [1:0]  i_req;
    logic [7:0]  i_cmd0;
    logic [23:0] i_data0;
    logic [7:0]  i_cmd1;
    logic [23:0] i_data1;
    logic [1:0]  o_ack;
    logic        o_tx_en;
    logic [7:0]  o_tx_data;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_gnt_id;
    logic        o_frame_done;
    logic        o_err;

    modport slave (
        input  i_req, i_cmd0, i_data0, i_cmd1, i_data1, i_tx_done,
        output o_ack, o_tx_en, o_tx_data, o_busy, o_gnt_id, o_frame_done, o_err
    );

    modport master (
        output i_req, i_cmd0, i_data0, i_cmd1, i_data1, i_tx_done,
        input  o_ack, o_tx_en, o_tx_data, o_busy, o_gnt_id, o_frame_done, o_err
    );
endinterface

// File: rtl/m_tx_frame_arb.sv
// Round-robin arbiter for two frame requesters that sequences a shared byte
// transmitter through a 7-byte frame: header, length, cmd, 3 payload, checksum.
module m_tx_frame_arb #(
    parameter logic [7:0] HEADER      = 8'h40,
    parameter logic [7:0] LEN         = 8'h05,
    parameter int         TIMEOUT_CYC = 8191
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    m_tx_frame_arb_if.slave   bus
);

    // ACK sits between the grant edge and the first SEND so o_ack pulses
    // one cycle after the grant and the first byte starts one cycle later.
    typedef enum logic [1:0] {IDLE, ACK, SEND, WAIT} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] data_q, data_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [1:0]  ack_q, ack_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        win;
    logic [7:0]  cur_byte;

    assign win = bus.i_req[1] & (~bus.i_req[0] | ~last_q);

    always_comb begin
        cur_byte = HEADER;
        unique case (idx_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = LEN;
            3'd2:    cur_byte = cmd_q;
            3'd3:    cur_byte = data_q[23:16];
            3'd4:    cur_byte = data_q[15:8];
            3'd5:    cur_byte = data_q[7:0];
            default: cur_byte = (~acc_q) + 8'd1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        ack_d     = 2'b00;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req != 2'b00) begin
                    cmd_d   = win ? bus.i_cmd1 : bus.i_cmd0;
                    data_d  = win ? bus.i_data1 : bus.i_data0;
                    gnt_d   = win;
                    last_d  = win;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                    acc_d   = 8'd0;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d   = gnt_q ? 2'b10 : 2'b01;
                state_d = SEND;
            end
            SEND: begin
                tx_en_d   = 1'b1;
                tx_data_d = cur_byte;
                acc_d     = acc_q + cur_byte;
                cnt_d     = 16'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A done arriving on the timeout edge still wins over the abort.
                if (bus.i_tx_done) begin
                    if (idx_q == 3'd6) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            acc_q     <= 8'd0;
            cnt_q     <= 16'd0;
            cmd_q     <= 8'd0;
            data_q    <= 24'd0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            ack_q     <= 2'b00;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_ack        = ack_q;
    assign bus.o_tx_en      = tx_en_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_gnt_id     = gnt_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_m_tx_frame_arb.sv
// Directed and randomized frames for m_tx_frame_arb, checked against a
// frame/round-robin reference model kept in the bench.
module tb_m_tx_frame_arb;

    localparam int TIMEOUT_CYC = 8191;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   lastServed = 1'b1;
    logic [7:0] expBytes [7];

    m_tx_frame_arb_if bus();

    m_tx_frame_arb #(
        .HEADER(8'h40),
        .LEN(8'h05),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [7:0] c0, input logic [23:0] d0,
                                 input logic [7:0] c1, input logic [23:0] d1);
        bus.i_req   = req;
        bus.i_cmd0  = c0;
        bus.i_data0 = d0;
        bus.i_cmd1  = c1;
        bus.i_data1 = d1;
    endtask

    // Frame model: checksum is whatever makes the 7-byte sum a multiple of 256.
    function automatic void buildFrame(input logic [7:0] c, input logic [23:0] d);
        int s;
        expBytes[0] = 8'h40;
        expBytes[1] = 8'h05;
        expBytes[2] = c;
        expBytes[3] = d[23:16];
        expBytes[4] = d[15:8];
        expBytes[5] = d[7:0];
        s = 0;
        for (int i = 0; i < 6; i++) s += int'(expBytes[i]);
        expBytes[6] = 8'((256 - (s % 256)) % 256);
    endfunction

    function automatic bit pickWinner(input logic [1:0] req);
        if (req == 2'b01) return 1'b0;
        if (req == 2'b10) return 1'b1;
        return ~lastServed;
    endfunction

    task automatic runFrame(input logic [1:0] reqMask, input logic [1:0] dropMask, input int doneDelay,
                            input int stallAt, input int resetAt, input bit injectSend);
        bit w;
        int n;
        int sum;
        w = pickWinner(reqMask);
        buildFrame(w ? bus.i_cmd1 : bus.i_cmd0, w ? bus.i_data1 : bus.i_data0);
        lastServed = w;

        n = 0;
        while (bus.o_ack === 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ack", {30'd0, bus.o_ack}, w ? 32'd2 : 32'd1);
        checkOutput("busyAtAck", {31'd0, bus.o_busy}, 32'd1);
        checkOutput("gntAtAck", {31'd0, bus.o_gnt_id}, {31'd0, w});
        bus.i_req = bus.i_req & ~dropMask;
        if (injectSend) bus.i_tx_done = 1'b1;

        sum = 0;
        for (int k = 0; k < 7; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                bus.i_tx_done = injectSend && k > 0 && n == 1;
            end while (bus.o_tx_en !== 1'b1 && n < 50);
            checkOutput($sformatf("txLatency%0d", k), n, (k == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("txData%0d", k), {24'd0, bus.o_tx_data}, {24'd0, expBytes[k]});
            checkOutput($sformatf("gnt%0d", k), {31'd0, bus.o_gnt_id}, {31'd0, w});
            sum += int'(bus.o_tx_data);

            if (k == resetAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput("outputsInReset",
                    {18'd0, bus.o_ack, bus.o_tx_en, bus.o_tx_data, bus.o_busy, bus.o_gnt_id,
                     bus.o_frame_done, bus.o_err}, 32'd0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    checkOutput("quietInReset", {29'd0, bus.o_tx_en, bus.o_frame_done, bus.o_err}, 32'd0);
                end
                rst_n = 1'b1;
                lastServed = 1'b1;
                @(negedge clk);
                checkOutput("quietAfterReset", {29'd0, bus.o_tx_en, bus.o_frame_done, bus.o_err}, 32'd0);
                return;
            end

            if (k == stallAt) begin
                n = 0;
                while (bus.o_err !== 1'b1 && n < TIMEOUT_CYC + 20) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("errLatency", n, TIMEOUT_CYC);
                checkOutput("busyAfterErr", {31'd0, bus.o_busy}, 32'd0);
                checkOutput("noDoneOnErr", {31'd0, bus.o_frame_done}, 32'd0);
                @(negedge clk);
                checkOutput("errPulse", {31'd0, bus.o_err}, 32'd0);
                return;
            end

            for (int j = 0; j < doneDelay; j++) begin
                @(negedge clk);
                if (j == 0) checkOutput("txEnPulse", {31'd0, bus.o_tx_en}, 32'd0);
            end
            bus.i_tx_done = 1'b1;
        end

        @(negedge clk);
        bus.i_tx_done = 1'b0;
        checkOutput("frameDone", {31'd0, bus.o_frame_done}, 32'd1);
        checkOutput("busyAfterFrame", {31'd0, bus.o_busy}, 32'd0);
        checkOutput("noErrOnFrame", {31'd0, bus.o_err}, 32'd0);
        checkOutput("frameSum", sum % 256, 32'd0);
        @(negedge clk);
        checkOutput("frameDonePulse", {31'd0, bus.o_frame_done}, 32'd0);
    endtask

    initial begin
        logic [1:0] pend;
        logic [1:0] mask;
        bit w;

        applyStimulus(2'b00, 8'h00, 24'h0, 8'h00, 24'h0);
        bus.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetState",
            {18'd0, bus.o_ack, bus.o_tx_en, bus.o_tx_data, bus.o_busy, bus.o_gnt_id,
             bus.o_frame_done, bus.o_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray done pulse while idle must not start anything.
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        @(negedge clk);
        checkOutput("idleDoneIgnored", {30'd0, bus.o_busy, bus.o_tx_en}, 32'd0);

        applyStimulus(2'b01, 8'hEE, 24'h223344, 8'h00, 24'h0);
        runFrame(2'b01, 2'b01, 20, -1, -1, 1'b0);

        applyStimulus(2'b10, 8'h00, 24'h0, 8'h55, 24'h000001);
        runFrame(2'b10, 2'b10, 20, -1, -1, 1'b0);

        // Both requesters held for three frames: expect 0,1,0.
        applyStimulus(2'b11, 8'($urandom), 24'($urandom), 8'($urandom), 24'($urandom));
        runFrame(2'b11, 2'b00, $urandom_range(1, 30), -1, -1, 1'b0);
        runFrame(2'b11, 2'b00, $urandom_range(1, 30), -1, -1, 1'b0);
        runFrame(2'b11, 2'b11, $urandom_range(1, 30), -1, -1, 1'b0);

        applyStimulus(2'b01, 8'($urandom), 24'($urandom), 8'h00, 24'h0);
        runFrame(2'b01, 2'b01, 5, 2, -1, 1'b0);
        applyStimulus(2'b10, 8'h00, 24'h0, 8'($urandom), 24'($urandom));
        runFrame(2'b10, 2'b10, $urandom_range(1, 30), -1, -1, 1'b0);

        applyStimulus(2'b01, 8'($urandom), 24'($urandom), 8'h00, 24'h0);
        runFrame(2'b01, 2'b01, 10, -1, 4, 1'b0);
        applyStimulus(2'b10, 8'h00, 24'h0, 8'($urandom), 24'($urandom));
        runFrame(2'b10, 2'b10, $urandom_range(1, 30), -1, -1, 1'b0);

        applyStimulus(2'b01, 8'($urandom), 24'($urandom), 8'h00, 24'h0);
        runFrame(2'b01, 2'b01, $urandom_range(2, 30), -1, -1, 1'b1);

        // Random traffic; a losing requester keeps its request and data.
        pend = 2'b00;
        for (int i = 0; i < 6; i++) begin
            mask = pend | 2'($urandom_range(1, 3));
            if (!pend[0]) begin
                bus.i_cmd0  = 8'($urandom);
                bus.i_data0 = 24'($urandom);
            end
            if (!pend[1]) begin
                bus.i_cmd1  = 8'($urandom);
                bus.i_data1 = 24'($urandom);
            end
            bus.i_req = mask;
            w = pickWinner(mask);
            runFrame(mask, w ? 2'b10 : 2'b01, $urandom_range(1, 30), -1, -1, 1'($urandom_range(0, 1)));
            pend = mask & ~(w ? 2'b10 : 2'b01);
        end
        if (pend != 2'b00) runFrame(pend, pend, $urandom_range(1, 30), -1, -1, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("finalIdle", {31'd0, bus.o_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
